// File: rtl/ssd_pkg.sv
// Shared constants and types for the shared-segment display scan path.
package ssd_pkg;

    localparam int SSD_DIGIT_W = 4;
    localparam logic [6:0] SSD_SEG_OFF = 7'b1111111;
    localparam int SSD_DIGITS_DEF = 4;

    typedef logic [$clog2(SSD_DIGITS_DEF)-1:0] ssd_idx_t;

    // A single-digit display still needs a one-bit index register.
    function automatic int ssd_idx_w(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/ssd_refresh_prescaler.sv
// Digit-slot prescaler: one tick every REFRESH_DIV enabled clocks, frozen while en=0.
module ssd_refresh_prescaler #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] count;

    // Gated by en so a frozen count sitting at LAST cannot tick repeatedly.
    assign tick = en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ssd_scan_controller.sv
// Double-buffered hex word scanner for a multiplexed display; one digit per refresh slot.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load_valid,
    input  logic [SSD_DIGIT_W*DIGITS-1:0] load_data,
    output logic                          load_ready,
    output logic [SSD_DIGIT_W-1:0]        nibble,
    output logic [DIGITS-1:0]             digit_en_n,
    output logic                          blank,
    output logic                          frame_done
);

    localparam int DATA_W = SSD_DIGIT_W * DIGITS;
    localparam int IDX_W  = ssd_idx_w(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic              tick;
    logic              wrap;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] active;
    logic              pending;
    logic              en_q;

    ssd_refresh_prescaler #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    assign wrap = tick && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // Accept needs pending=0 and transfer needs pending=1, so the two never collide;
    // a word accepted on a wrap edge therefore waits for the following wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (load_valid && !pending) begin
            shadow  <= load_data;
            pending <= 1'b1;
        end else if (wrap && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end
    end

    // en is registered so digit enables never follow an input combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            en_q       <= 1'b1;
        end else begin
            frame_done <= wrap;
            en_q       <= en;
        end
    end

    assign load_ready = ~pending;
    assign nibble     = active[SSD_DIGIT_W*idx +: SSD_DIGIT_W];
    assign digit_en_n = en_q ? ~(DIGITS'(1) << idx) : '1;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // zero_from[d]: digit d and every digit above it are zero.
    logic [DIGITS:0] zero_from;

    always_comb begin
        zero_from         = '0;
        zero_from[DIGITS] = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            zero_from[d] = zero_from[d+1] && (active[SSD_DIGIT_W*d +: SSD_DIGIT_W] == '0);
        end
    end

    assign blank = (idx != '0) && zero_from[idx];
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed scoreboard bench for ssd_scan_controller with DIGITS=4, REFRESH_DIV=4.
module tb_ssd_scan_controller;
    import ssd_pkg::*;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int DATA_W      = SSD_DIGIT_W * DIGITS;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic                   load_valid;
    logic [DATA_W-1:0]      load_data;
    logic                   load_ready;
    logic [SSD_DIGIT_W-1:0] nibble;
    logic [DIGITS-1:0]      digit_en_n;
    logic                   blank;
    logic                   frame_done;

    int n_pass  = 0;
    int n_total = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] cur;
    int                n_wait;

    always #5 clk = ~clk;

    ssd_scan_controller #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .nibble     (nibble),
        .digit_en_n (digit_en_n),
        .blank      (blank),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_blank(input logic [DATA_W-1:0] w, input int d);
        logic b;
        b = (d != 0) && ((w >> (SSD_DIGIT_W * d)) == '0);
`ifndef SSD_LEADING_ZERO_BLANK_EN
        b = 1'b0;
`endif
        return b;
    endfunction

    // Starts on a frame's first cycle, walks all 16 cycles, ends on the next frame's first cycle.
    task automatic check_frame(input logic [DATA_W-1:0] w, input logic first_fd);
        logic [DIGITS-1:0]      en_exp;
        logic [SSD_DIGIT_W-1:0] nib_exp;
        for (int d = 0; d < DIGITS; d++) begin
            for (int k = 0; k < REFRESH_DIV; k++) begin
                en_exp  = ~(4'b0001 << d);
                nib_exp = w[SSD_DIGIT_W*d +: SSD_DIGIT_W];
                check($sformatf("nibble_d%0d_k%0d", d, k), 32'(nibble), 32'(nib_exp));
                check($sformatf("digit_en_n_d%0d_k%0d", d, k), 32'(digit_en_n), 32'(en_exp));
                check($sformatf("blank_d%0d_k%0d", d, k), 32'(blank), 32'(exp_blank(w, d)));
                check($sformatf("frame_done_d%0d_k%0d", d, k), 32'(frame_done),
                      (d == 0 && k == 0) ? 32'(first_fd) : 32'd0);
                step();
            end
        end
        check("frame_done_wrap", 32'(frame_done), 32'd1);
    endtask

    task automatic wait_fd(input int bound, input logic chk_not_ready, output int n);
        n = 0;
        while (frame_done !== 1'b1 && n < bound) begin
            if (chk_not_ready) check("load_ready_low_while_pending", 32'(load_ready), 32'd0);
            step();
            n++;
        end
        check("frame_done_reached", 32'(frame_done), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_nibble", 32'(nibble), 32'd0);
        check("rst_digit_en_n", 32'(digit_en_n), 32'hE);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_blank", 32'(blank), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        check("post_rst_digit_en_n", 32'(digit_en_n), 32'hE);
        check("post_rst_load_ready", 32'(load_ready), 32'd1);

        // Frame straight out of reset shows zero.
        check_frame('0, 1'b0);

        // Single load becomes visible at the next frame.
        load_data  = 16'h1A2F;
        load_valid = 1'b1;
        exp_q.push_back(16'h1A2F);
        step();
        load_valid = 1'b0;
        check("ready_after_load", 32'(load_ready), 32'd0);
        wait_fd(40, 1'b1, n_wait);
        cur = exp_q.pop_front();
        check("ready_after_wrap", 32'(load_ready), 32'd1);
        check_frame(cur, 1'b1);

        // Back-to-back loads: the second is refused.
        load_data  = 16'h1234;
        load_valid = 1'b1;
        exp_q.push_back(16'h1234);
        step();
        load_data = 16'h5678;
        check("second_word_refused", 32'(load_ready), 32'd0);
        step();
        check("second_word_refused_hold", 32'(load_ready), 32'd0);
        step();
        load_valid = 1'b0;
        wait_fd(40, 1'b1, n_wait);
        cur = exp_q.pop_front();
        check("ready_after_1234_wrap", 32'(load_ready), 32'd1);
        check_frame(cur, 1'b1);
        load_data  = 16'h5678;
        load_valid = 1'b1;
        exp_q.push_back(16'h5678);
        step();
        load_valid = 1'b0;
        check("5678_accepted", 32'(load_ready), 32'd0);
        wait_fd(40, 1'b1, n_wait);
        cur = exp_q.pop_front();
        check_frame(cur, 1'b1);

        // Load lands on the boundary edge itself: old word stays for one more frame.
        check("ready_before_boundary_load", 32'(load_ready), 32'd1);
        repeat (DIGITS * REFRESH_DIV - 1) step();
        load_data  = 16'h0050;
        load_valid = 1'b1;
        exp_q.push_back(16'h0050);
        step();
        load_valid = 1'b0;
        check("boundary_load_pending", 32'(load_ready), 32'd0);
        check_frame(cur, 1'b1);
        cur = exp_q.pop_front();
        check("boundary_load_transferred", 32'(load_ready), 32'd1);
        check_frame(cur, 1'b1);

        // Pause mid-frame at digit 1; handshake still works while paused.
        repeat (5) step();
        check("pre_pause_digit_en_n", 32'(digit_en_n), 32'hD);
        en         = 1'b0;
        load_data  = 16'h0009;
        load_valid = 1'b1;
        exp_q.push_back(16'h0009);
        for (int i = 0; i < 10; i++) begin
            step();
            load_valid = 1'b0;
            check("paused_digit_en_n", 32'(digit_en_n), 32'hF);
            check("paused_nibble", 32'(nibble), 32'h5);
            check("paused_frame_done", 32'(frame_done), 32'd0);
            check("paused_load_ready", 32'(load_ready), 32'd0);
        end
        en = 1'b1;
        step();
        check("resume_digit_en_n", 32'(digit_en_n), 32'hD);
        check("resume_nibble", 32'(nibble), 32'h5);
        wait_fd(40, 1'b1, n_wait);
        check("resume_cycles_to_wrap", 32'(n_wait), 32'd10);
        cur = exp_q.pop_front();
        check_frame(cur, 1'b1);

        // Asynchronous reset mid-frame with a pending word discards it.
        load_data  = 16'hBEEF;
        load_valid = 1'b1;
        exp_q.push_back(16'hBEEF);
        step();
        load_valid = 1'b0;
        repeat (8) step();
        check("pre_rst_digit_en_n", 32'(digit_en_n), 32'hB);
        check("pre_rst_load_ready", 32'(load_ready), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_nibble", 32'(nibble), 32'd0);
        check("async_rst_digit_en_n", 32'(digit_en_n), 32'hE);
        check("async_rst_load_ready", 32'(load_ready), 32'd1);
        check("async_rst_blank", 32'(blank), 32'd0);
        check("async_rst_frame_done", 32'(frame_done), 32'd0);
        exp_q.delete();
        step();
        rst = 1'b0;
        check("post_async_rst_digit_en_n", 32'(digit_en_n), 32'hE);
        check("post_async_rst_load_ready", 32'(load_ready), 32'd1);
        check_frame('0, 1'b0);
        check("final_load_ready", 32'(load_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
